// File: rtl/relm_ps2_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : relm_ps2_rx                                                   |
// | Purpose  : PS/2 device-to-host receiver for the ReLM system. Synchronizes|
// |            and glitch-filters the raw PS/2 clock/data pins, deframes     |
// |            11-bit frames (start, 8 data LSB first, odd parity, stop),    |
// |            buffers bytes in a 2**WAF deep FIFO and serves them on a ReLM |
// |            pop port.                                                     |
// | Ports    : clk        - system clock                                     |
// |            rst_n_in   - synchronous active-low reset                     |
// |            ps2_clk_in - raw PS/2 clock pin (asynchronous)                |
// |            ps2_dat_in - raw PS/2 data pin (asynchronous)                 |
// |            pop_d      - pop request, bit WD = pop this cycle             |
// |            pop_q      - {retry, zeros, overrun, parity err, byte}        |
// | Options  : PS2_ERRFLAG_EN - when defined, parity-error frames are queued |
// |            with pop_q[8]=1; otherwise they are dropped and pop_q[8]=0.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module relm_ps2_rx #(
  parameter int WD      = 32,
  parameter int WAF     = 4,
  parameter int NFILT   = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic          clk,
  input  logic          rst_n_in,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  input  logic [WD:0]   pop_d,
  output logic [WD:0]   pop_q
);

  localparam int c_DEPTH = 2 ** WAF;
  localparam int c_TOW   = $clog2(TIMEOUT + 1);
`ifdef PS2_ERRFLAG_EN
  localparam int c_EW    = 9;
`else
  localparam int c_EW    = 8;
`endif

  // ---------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer, then an NFILT-sample filter
  // whose output only moves when every sample in the window agrees.
  // ---------------------------------------------------------------------
  logic [1:0]       r_clk_sync, r_dat_sync;
  logic [NFILT-1:0] r_clk_sr, r_dat_sr;
  logic             r_clk_f, r_dat_f, r_clk_f_d;

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_sr   <= '1;
      r_dat_sr   <= '1;
      r_clk_f    <= 1'b1;
      r_dat_f    <= 1'b1;
      r_clk_f_d  <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
      r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
      r_clk_sr   <= {r_clk_sr[NFILT-2:0], r_clk_sync[1]};
      r_dat_sr   <= {r_dat_sr[NFILT-2:0], r_dat_sync[1]};
      if (&r_clk_sr)       r_clk_f <= 1'b1;
      else if (~|r_clk_sr) r_clk_f <= 1'b0;
      if (&r_dat_sr)       r_dat_f <= 1'b1;
      else if (~|r_dat_sr) r_dat_f <= 1'b0;
      r_clk_f_d  <= r_clk_f;
    end
  end

  logic w_fall, w_bit;
  assign w_fall = r_clk_f_d & ~r_clk_f;
  assign w_bit  = r_dat_f;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_shreg, w_shreg_nxt;
  logic [2:0]       r_bitcnt, w_bitcnt_nxt;
  logic             r_perr, w_perr_nxt;
  logic             r_wr_req, w_wr_req_nxt;
  logic [c_TOW-1:0] r_to_cnt, w_to_cnt_nxt;
  logic             w_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_perr   <= 1'b0;
      r_wr_req <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_perr   <= w_perr_nxt;
      r_wr_req <= w_wr_req_nxt;
      r_to_cnt <= w_to_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_perr_nxt   = r_perr;
    w_wr_req_nxt = 1'b0;
    w_to_cnt_nxt = r_to_cnt;
    w_timeout    = (r_state != S_IDLE) && (r_to_cnt == c_TOW'(TIMEOUT - 1));

    // Watchdog only runs while a frame is in progress.
    if (r_state == S_IDLE || w_fall || w_timeout) w_to_cnt_nxt = '0;
    else                                          w_to_cnt_nxt = r_to_cnt + 1'b1;

    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!w_bit) begin
            w_state_nxt  = S_DATA;
            w_bitcnt_nxt = '0;
          end
        end
        S_DATA: begin
          w_shreg_nxt  = {w_bit, r_shreg[7:1]};
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
        end
        S_PARITY: begin
          // Odd parity: data bits plus parity bit must hold an odd count of ones.
          w_perr_nxt  = ~(^r_shreg ^ w_bit);
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (w_bit) begin
`ifdef PS2_ERRFLAG_EN
            w_wr_req_nxt = 1'b1;
`else
            w_wr_req_nxt = ~r_perr;
`endif
          end
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------
  logic [c_EW-1:0] r_mem [c_DEPTH];
  logic [WAF-1:0]  r_wr_ptr, r_rd_ptr;
  logic [WAF:0]    r_count;
  logic            r_ovr;
  logic            w_empty, w_full, w_pop, w_push;
  logic [c_EW-1:0] w_entry, w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (WAF+1)'(c_DEPTH));
  assign w_pop   = pop_d[WD] & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push  = r_wr_req & (~w_full | w_pop);
  assign w_head  = r_mem[r_rd_ptr];
`ifdef PS2_ERRFLAG_EN
  assign w_entry = {r_perr, r_shreg};
`else
  assign w_entry = r_shreg;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop)                    r_ovr <= 1'b0;
      else if (r_wr_req && w_full)  r_ovr <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Pop response; data fields are masked while empty so stale or
  // never-written entries are not exposed.
  // ---------------------------------------------------------------------
  always_comb begin
    pop_q      = '0;
    pop_q[WD]  = w_empty;
    pop_q[9]   = r_ovr;
`ifdef PS2_ERRFLAG_EN
    pop_q[8]   = ~w_empty & w_head[8];
`else
    pop_q[8]   = 1'b0;
`endif
    pop_q[7:0] = w_empty ? 8'h00 : w_head[7:0];
  end

  logic w_unused_pop;
  assign w_unused_pop = ^pop_d[WD-1:0];

endmodule
`default_nettype wire

// File: doc/relm_ps2_rx.md
Name: relm_ps2_rx

Overview:
- Hardware PS/2 receive stage for the DE0-CV ReLM system; replaces software bit-banging of the PS/2 clock/data lines.
- Samples the raw PS/2 clock and data pins, deframes 11-bit device-to-host frames and checks odd parity.
- Buffers received bytes in a small FIFO.
- Presents the buffered bytes on a standard ReLM pop port (pop_d/pop_q pair), directly feeding the processor's pop bus.

Parameters:
- WD, 32, ReLM data width; the pop port buses are WD+1 bits.
- WAF, 4, FIFO address width; depth is 2**WAF bytes.
- NFILT, 8, glitch-filter length in clk samples.
- TIMEOUT, 100000, clk cycles without a falling PS/2 clock edge before a partial frame is abandoned.

Ports:
- clk  input  1  system clock, single clock domain.
- rst_n_in  input  1  reset; synchronous, active-low.
- ps2_clk_in  input  1  raw PS/2 clock pin, asynchronous.
- ps2_dat_in  input  1  raw PS/2 data pin, asynchronous.
- pop_d  input  WD+1  pop request from ReLM; bit WD=1 means pop this cycle.
- pop_q  output  WD+1  pop response:
  - [WD] retry (1 = FIFO empty)
  - [WD-1:10] zero
  - [9] overrun flag
  - [8] parity-error flag
  - [7:0] head byte

Behaviour:
- Reset (rst_n_in low at a clk edge): FSM to IDLE; FIFO pointers and count to 0; overrun flag cleared; filters preset to all-ones; timeout counter cleared.
  - pop_q is {1'b1, WD'b0} from the cycle after reset, until the first byte is written.
  - Reset asserted mid-frame discards the partial frame.
- Input conditioning:
  - Each pin passes a 2-flop synchronizer, then an NFILT-bit shift filter.
  - The filtered level changes only when all NFILT samples agree; otherwise it holds.
  - A falling edge is the filtered clock going 1->0. The data bit used is the filtered data level in that same cycle.
- FSM, advancing on falling edges:
  - IDLE: on edge with data=0 (start bit) go to DATA, clear the bit counter. Data=1 stays in IDLE.
  - DATA: shift the data bit into shreg[7] (LSB first); after the 8th bit go to PARITY.
  - PARITY: capture the parity bit; perr = ~(^shreg ^ bit), i.e. odd parity required. Go to STOP.
  - STOP:
    - If data=1: frame valid; issue a write request; go to IDLE.
    - If data=0: framing error; discard the frame; go to IDLE.
- Timeout:
  - The counter increments in every non-IDLE cycle without an edge and clears on every edge.
  - Reaching TIMEOUT-1 forces IDLE and discards the frame. It is never active in IDLE.
- FIFO write:
  - Occurs in the cycle after the stop-bit edge. Entry = {perr, shreg}.
  - Parity-error frames are written only if PS2_ERRFLAG_EN is defined; otherwise they are dropped.
  - If full: the byte is dropped, the overrun flag is set (sticky), and FIFO contents are unchanged.
- Pop:
  - pop_q is combinational from the head entry, the overrun flag and the empty status.
  - pop_d[WD]=1 with FIFO non-empty: read pointer advances at that clk edge, and the overrun flag clears at the same edge.
  - pop_d[WD]=1 with FIFO empty: no effect. retry=1 tells ReLM to reissue the pop.
- Simultaneous push and pop:
  - On a non-empty FIFO, both occur and the count is unchanged.
  - On an empty FIFO, the push lands and the pop is ignored; retry was 1 that cycle.
  - On a full FIFO with a simultaneous pop, the write succeeds (the slot is freed) and no overrun is flagged.
- Pointers wrap modulo 2**WAF. Full is count==2**WAF, empty is count==0; count is WAF+1 bits.
- Latency: a byte is visible on pop_q[7:0] with retry=0 two clk cycles after the stop-bit falling edge at the filter output.

Optional Feature:
- Macro: PS2_ERRFLAG_EN.
- Defined: parity-error frames are enqueued with pop_q[8]=1.
- Undefined:
  - Parity-error frames are silently dropped.
  - pop_q[8] is tied to 0 and the FIFO entry width is 8 bits.

Test Plan:
- Reset then idle pins high -> pop_q[WD]=1, pop_q[9:0]=0; pop_d[WD]=1 changes nothing.
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> pop_q[7:0]=0x1C, [8]=0, retry=0; after one pop, retry=1.
- Parity bit flipped on 0x1C:
  - With PS2_ERRFLAG_EN, pop_q=0x11C with retry=0.
  - Without it, retry stays 1.
- 17 frames 0x00..0x10 with no pops (WAF=4) -> 16 bytes 0x00..0x0F are readable with [9]=1 on the first read only; 0x10 is lost.
- Frame cut after 4 data bits, idle for TIMEOUT cycles, then a full frame 0xF0 -> only 0xF0 is received.
  - 1-sample glitches on ps2_clk_in (NFILT=8) produce no bit shifts.
- rst_n_in pulsed low mid-frame and after 3 buffered bytes -> FIFO empty and overrun cleared.
  - A subsequent clean frame 0x5A is received correctly.
